// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads program memory one word at a time and hands it
// to the decoder through a valid/ready handshake. Supports redirects and parking.
module instruction_fetch #(
    parameter int          AWIDTH   = 15,
    parameter int          DWIDTH   = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              jump,
    input  logic [AWIDTH-1:0] jump_addr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DWIDTH-1:0] mem_data,
    output logic [DWIDTH-1:0] instr,
    output logic [AWIDTH-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       fetch_count
);

    localparam logic [AWIDTH-1:0] START_PC = AWIDTH'(RESET_PC);

    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

    state_t            state;
    logic [AWIDTH-1:0] pc;
    logic              handshake;

    assign handshake = instr_valid & instr_ready;
    assign mem_addr  = pc;
    assign mem_wr    = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= START_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            mem_rd      <= 1'b0;
            fetch_count <= '0;
        end else begin
            // An accepted instruction still counts when a redirect lands on the same edge.
            if (handshake && fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;

            if (jump) begin
                pc          <= jump_addr;
                instr_valid <= 1'b0;
                mem_rd      <= en;
                state       <= en ? FETCH : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (en) begin
                            state  <= FETCH;
                            mem_rd <= 1'b1;
                        end
                    end
                    FETCH: begin
                        instr       <= mem_data;
                        instr_pc    <= pc;
                        pc          <= pc + AWIDTH'(1);
                        instr_valid <= 1'b1;
                        mem_rd      <= 1'b0;
                        state       <= VALID;
                    end
                    VALID: begin
                        if (handshake) begin
                            instr_valid <= 1'b0;
                            mem_rd      <= en;
                            state       <= en ? FETCH : IDLE;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        instr_valid <= 1'b0;
                        mem_rd      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a transaction-level model checked every
// cycle, plus literal expectations for the key scenarios and a narrow-address wrap case.
module tb_instruction_fetch;

    localparam int AW = 15;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, en, jump, instr_ready;
    logic [AW-1:0] jump_addr;

    logic [AW-1:0] mem_addr, instr_pc;
    logic          mem_rd, mem_wr, instr_valid;
    logic [DW-1:0] mem_data, instr;
    logic [15:0]   fetch_count;

    logic [3:0]    s_mem_addr, s_instr_pc;
    logic          s_mem_rd, s_mem_wr, s_instr_valid;
    logic [DW-1:0] s_mem_data, s_instr;
    logic [15:0]   s_fetch_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 + (a & 32'h0000_FFFF);
    endfunction

    assign mem_data   = word(32'(mem_addr));
    assign s_mem_data = word(32'(s_mem_addr));

    instruction_fetch #(.AWIDTH(AW), .DWIDTH(DW), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .en(en), .jump(jump), .jump_addr(jump_addr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data(mem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fetch_count(fetch_count)
    );

    instruction_fetch #(.AWIDTH(4), .DWIDTH(DW), .RESET_PC(0)) dut_small (
        .clk(clk), .rst(rst), .en(en), .jump(jump), .jump_addr(jump_addr[3:0]),
        .mem_addr(s_mem_addr), .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .mem_data(s_mem_data),
        .instr(s_instr), .instr_pc(s_instr_pc), .instr_valid(s_instr_valid),
        .instr_ready(instr_ready), .fetch_count(s_fetch_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: what the unit owes the decoder, where it reads next, what it has delivered.
    int unsigned m_pc = 0;
    bit          m_reading = 0;
    bit          m_holding = 0;
    logic [31:0] m_word = '0;
    int unsigned m_word_pc = 0;
    int unsigned m_count = 0;
    bit          m_accept;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_reading = 0; m_holding = 0; m_count = 0;
        end else begin
            m_accept = m_holding && instr_ready;
            if (m_accept && m_count < 65535) m_count++;
            if (jump) begin
                m_pc = 32'(jump_addr); m_holding = 0; m_reading = en;
            end else if (m_reading) begin
                m_word = word(m_pc); m_word_pc = m_pc; m_holding = 1; m_reading = 0;
                m_pc = (m_pc + 1) % (1 << AW);
            end else if (m_holding) begin
                if (m_accept) begin m_holding = 0; m_reading = en; end
            end else begin
                m_reading = en;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_valid", 32'(instr_valid), 32'(m_holding));
        chk("model_rd", 32'(mem_rd), 32'(m_reading));
        chk("model_wr", 32'(mem_wr), 32'd0);
        chk("model_addr", 32'(mem_addr), m_pc);
        chk("model_count", 32'(fetch_count), m_count);
        if (m_holding) begin
            chk("model_instr", instr, m_word);
            chk("model_ipc", 32'(instr_pc), m_word_pc);
        end
    end

    // Record the address of every instruction the narrow unit hands over.
    int unsigned s_log[$];
    always @(negedge clk)
        if (!rst && s_instr_valid && instr_ready) s_log.push_back(32'(s_instr_pc));

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [31:0] exp_word [4] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};

    initial begin
        rst = 1'b1; en = 1'b0; jump = 1'b0; jump_addr = '0; instr_ready = 1'b0;
        #2;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_instr", instr, 32'd0);

        // Sequential stream A..D, valid after edges 2,4,6,8.
        tick(2);
        rst = 1'b0; en = 1'b1; instr_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            chk("seq_valid", 32'(instr_valid), 32'((k % 2) == 0));
            if (k % 2 == 0) begin
                chk("seq_instr", instr, exp_word[k/2-1]);
                chk("seq_ipc", 32'(instr_pc), 32'(k/2-1));
            end
        end
        chk("seq_count", 32'(fetch_count), 32'd4);

        // Stall: held instruction must stay put.
        instr_ready = 1'b0;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_ipc", 32'(instr_pc), 32'd4);
            chk("stall_instr", instr, 32'hC0DE0004);
            chk("stall_rd", 32'(mem_rd), 32'd0);
        end
        instr_ready = 1'b1;
        tick(1);
        chk("stall_accept", 32'(fetch_count), 32'd5);

        // Redirect during a held instruction: dropped, not counted.
        instr_ready = 1'b0;
        tick(1);
        jump = 1'b1; jump_addr = 15'h0100;
        tick(1);
        jump = 1'b0;
        chk("jmp_drop", 32'(instr_valid), 32'd0);
        chk("jmp_count", 32'(fetch_count), 32'd5);
        chk("jmp_addr", 32'(mem_addr), 32'h0100);
        tick(1);
        chk("jmp_ipc", 32'(instr_pc), 32'h0100);
        chk("jmp_instr", instr, 32'hC0DE0100);

        // Redirect coinciding with a handshake: counted, redirect still wins.
        instr_ready = 1'b1; jump = 1'b1; jump_addr = 15'h0200;
        tick(1);
        jump = 1'b0;
        chk("jhs_count", 32'(fetch_count), 32'd6);
        chk("jhs_addr", 32'(mem_addr), 32'h0200);
        tick(1);
        chk("jhs_ipc", 32'(instr_pc), 32'h0200);

        // Redirect during a read: word discarded.
        tick(1);
        jump = 1'b1; jump_addr = 15'h0300;
        tick(1);
        jump = 1'b0;
        chk("jf_valid", 32'(instr_valid), 32'd0);
        chk("jf_count", 32'(fetch_count), 32'd7);
        tick(1);
        chk("jf_ipc", 32'(instr_pc), 32'h0300);

        // Park on handshake, then resume sequentially.
        en = 1'b0;
        tick(1);
        chk("park_count", 32'(fetch_count), 32'd8);
        tick(3);
        chk("park_rd", 32'(mem_rd), 32'd0);
        chk("park_valid", 32'(instr_valid), 32'd0);
        en = 1'b1;
        tick(2);
        chk("resume_ipc", 32'(instr_pc), 32'h0301);

        // Enable dropping mid-read still completes the read.
        tick(1);
        en = 1'b0;
        tick(1);
        chk("enfall_ipc", 32'(instr_pc), 32'h0302);
        chk("enfall_valid", 32'(instr_valid), 32'd1);
        tick(1);
        chk("enfall_count", 32'(fetch_count), 32'd10);

        // Asynchronous reset mid-read at pc 5.
        jump = 1'b1; jump_addr = 15'h0005; en = 1'b1;
        tick(1);
        jump = 1'b0;
        chk("pre_rst_rd", 32'(mem_rd), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_count", 32'(fetch_count), 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_ipc", 32'(instr_pc), 32'd0);
        chk("arst_rd", 32'(mem_rd), 32'd0);
        chk("arst_addr", 32'(mem_addr), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("post_rst_ipc", 32'(instr_pc), 32'd0);
        chk("post_rst_valid", 32'(instr_valid), 32'd1);

        // Narrow address: pc 15 wraps to 0.
        rst = 1'b1;
        tick(1);
        s_log.delete();
        rst = 1'b0; en = 1'b1; instr_ready = 1'b1;
        tick(36);
        chk("wrap_len", 32'(s_log.size() >= 17), 32'd1);
        if (s_log.size() >= 17) begin
            chk("wrap_15", s_log[15], 32'd15);
            chk("wrap_0", s_log[16], 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
